vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_if.sv | 46 ++++
 rtl/vga_sync_gen.sv | 137 +++++++++++++
 tb/tb_vga_sync_gen.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_if.sv
// ---------------------------------------------------------------------------
// vga_sync_if
// Signal bundle between a VGA timing generator and its consumer.
//   i_enable       : advance the timing when high, freeze it when low
//   o_hsync        : horizontal sync, active-low
//   o_vsync        : vertical sync, active-low
//   o_col_counter  : current column, 0..TOTAL_COLS-1
//   o_row_counter  : current row, 0..TOTAL_ROWS-1
//   o_active       : current pixel is in the visible area
//   o_frame_start  : one-clock pulse when the counters reach (0,0)
// master : the side that drives i_enable and consumes the timing
// slave  : the timing generator itself
// ---------------------------------------------------------------------------
`default_nettype none

interface vga_sync_if;
  logic       i_enable;
  logic       o_hsync;
  logic       o_vsync;
  logic [9:0] o_col_counter;
  logic [9:0] o_row_counter;
  logic       o_active;
  logic       o_frame_start;

  modport master (
    output i_enable,
    input  o_hsync,
    input  o_vsync,
    input  o_col_counter,
    input  o_row_counter,
    input  o_active,
    input  o_frame_start
  );

  modport slave (
    input  i_enable,
    output o_hsync,
    output o_vsync,
    output o_col_counter,
    output o_row_counter,
    output o_active,
    output o_frame_start
  );
endinterface

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
// VGA raster timing generator: column/row counters plus registered sync,
// visible-area and frame-start decodes, all aligned to the same cycle.
//
// Ports
//   clk      : pixel clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   bus      : vga_sync_if.slave (i_enable in; sync/counters/active/frame out)
//
// Optional feature
//   VGA_SYNC_FRAME_PULSE_EN : when defined, o_frame_start pulses for one
//   clock as the counters advance to (0,0). When undefined, o_frame_start
//   is a constant 0 and no pulse register exists.
//
// Timing along a line: active | front porch | sync | back porch (remainder).
// The same layout applies to rows within a frame.
// ---------------------------------------------------------------------------
`default_nettype none

module vga_sync_gen #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_WIDTH  = 96,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_WIDTH  = 2
) (
  input  wire logic     clk,
  input  wire logic     i_rst_n,
  vga_sync_if.slave     bus
);

  // All timing arithmetic is unsigned 10-bit.
  localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] ACT_COLS = 10'(ACTIVE_COLS);
  localparam logic [9:0] ACT_ROWS = 10'(ACTIVE_ROWS);
  localparam logic [9:0] HS_FIRST = 10'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [9:0] HS_LAST  = 10'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
  localparam logic [9:0] VS_FIRST = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [9:0] VS_LAST  = 10'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);

  // Inclusive range test; an empty window (last < first) never matches.
  function automatic logic in_window(input logic [9:0] v,
                                     input logic [9:0] first,
                                     input logic [9:0] last);
    return (v >= first) && (v <= last);
  endfunction

  // Counter step with wrap. Using >= keeps a counter inside its range even
  // if it ever held an out-of-range value.
  function automatic logic [9:0] step_wrap(input logic [9:0] v,
                                           input logic [9:0] last);
    return (v >= last) ? 10'd0 : v + 10'd1;
  endfunction

  logic [9:0] col_p0;
  logic [9:0] row_p0;
  logic       hsync_p0;
  logic       vsync_p0;
  logic       active_p0;

  logic [9:0] col_nxt;
  logic [9:0] row_nxt;
  logic       col_wrap;
  logic       hsync_nxt;
  logic       vsync_nxt;
  logic       active_nxt;

  // Decodes are taken from the next counter values so that, once
  // registered, every output describes the counters shown in that cycle.
  always_comb begin
    col_wrap   = (col_p0 >= COL_LAST);
    col_nxt    = step_wrap(col_p0, COL_LAST);
    row_nxt    = row_p0;
    if (col_wrap) begin
      row_nxt  = step_wrap(row_p0, ROW_LAST);
    end
    hsync_nxt  = ~in_window(col_nxt, HS_FIRST, HS_LAST);
    vsync_nxt  = ~in_window(row_nxt, VS_FIRST, VS_LAST);
    active_nxt = (col_nxt < ACT_COLS) && (row_nxt < ACT_ROWS);
  end

  // ---- stage p0: registered counters and decodes ----
  // Reset parks the counters on the last pixel so the first enabled edge
  // lands exactly on (0,0).
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_p0    <= COL_LAST;
      row_p0    <= ROW_LAST;
      hsync_p0  <= 1'b1;
      vsync_p0  <= 1'b1;
      active_p0 <= 1'b0;
    end else if (bus.i_enable) begin
      col_p0    <= col_nxt;
      row_p0    <= row_nxt;
      hsync_p0  <= hsync_nxt;
      vsync_p0  <= vsync_nxt;
      active_p0 <= active_nxt;
    end
  end

`ifdef VGA_SYNC_FRAME_PULSE_EN
  logic frame_start_p0;
  logic at_origin_nxt;

  always_comb begin
    at_origin_nxt = (col_nxt == 10'd0) && (row_nxt == 10'd0);
  end

  // Unlike the other outputs this one does not hold while disabled: a
  // stall at (0,0) must not stretch the pulse, so it clears instead.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_start_p0 <= 1'b0;
    end else begin
      frame_start_p0 <= bus.i_enable && at_origin_nxt;
    end
  end

  assign bus.o_frame_start = frame_start_p0;
`else
  assign bus.o_frame_start = 1'b0;
`endif

  assign bus.o_col_counter = col_p0;
  assign bus.o_row_counter = row_p0;
  assign bus.o_hsync       = hsync_p0;
  assign bus.o_vsync       = vsync_p0;
  assign bus.o_active      = active_p0;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
// Directed bench for vga_sync_gen. Instance a uses the default 640x480
// timing (line-level checks); instance b uses a reduced raster so whole
// frames fit in a short run:
//   b: 40 cols (24 active, fp 4, sync 6 -> hsync cols 28..33)
//      16 rows (10 active, fp 2, sync 2 -> vsync rows 12..13), 640 clk/frame
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vga_sync_gen;

`ifdef VGA_SYNC_FRAME_PULSE_EN
  localparam int FS_ON = 1;
`else
  localparam int FS_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  vga_sync_if bus_a();
  vga_sync_if bus_b();

  vga_sync_gen u_dut_a (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus_a)
  );

  vga_sync_gen #(
    .TOTAL_COLS    (40),
    .TOTAL_ROWS    (16),
    .ACTIVE_COLS   (24),
    .ACTIVE_ROWS   (10),
    .H_FRONT_PORCH (4),
    .H_SYNC_WIDTH  (6),
    .V_FRONT_PORCH (2),
    .V_SYNC_WIDTH  (2)
  ) u_dut_b (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus_b)
  );

  int checks   = 0;
  int failures = 0;

  int ca, ra, hsa, vsa, aca, fsa;
  int cb, rb, hsb, vsb, acb, fsb;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic sample();
    ca  = int'(bus_a.o_col_counter);
    ra  = int'(bus_a.o_row_counter);
    hsa = int'(bus_a.o_hsync);
    vsa = int'(bus_a.o_vsync);
    aca = int'(bus_a.o_active);
    fsa = int'(bus_a.o_frame_start);
    cb  = int'(bus_b.o_col_counter);
    rb  = int'(bus_b.o_row_counter);
    hsb = int'(bus_b.o_hsync);
    vsb = int'(bus_b.o_vsync);
    acb = int'(bus_b.o_active);
    fsb = int'(bus_b.o_frame_start);
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
  endtask

  task automatic check_rst(input string pfx);
    chk({pfx, "_a_col"}, ca, 799);
    chk({pfx, "_a_row"}, ra, 524);
    chk({pfx, "_a_hs"},  hsa, 1);
    chk({pfx, "_a_vs"},  vsa, 1);
    chk({pfx, "_a_act"}, aca, 0);
    chk({pfx, "_a_fs"},  fsa, 0);
    chk({pfx, "_b_col"}, cb, 39);
    chk({pfx, "_b_row"}, rb, 15);
    chk({pfx, "_b_hs"},  hsb, 1);
    chk({pfx, "_b_vs"},  vsb, 1);
    chk({pfx, "_b_act"}, acb, 0);
    chk({pfx, "_b_fs"},  fsb, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_low, hs_first, hs_last, act_n, bad, found;
    int s_c, s_r, s_hs, s_vs, s_ac, s_fs;
    int org_n, org_first, org_last, fs_n, fs_bad, vs_low, vs_min, vs_max;

    rst_n = 1'b0;
    bus_a.i_enable = 1'b0;
    bus_b.i_enable = 1'b0;
    repeat (3) tick();
    check_rst("rst");

    // Release: first enabled edge lands on (0,0)
    rst_n = 1'b1;
    bus_a.i_enable = 1'b1;
    bus_b.i_enable = 1'b1;
    tick();
    chk("rel_a_col", ca, 0);
    chk("rel_a_row", ra, 0);
    chk("rel_a_fs",  fsa, FS_ON);
    chk("rel_a_act", aca, 1);
    chk("rel_a_hs",  hsa, 1);
    chk("rel_b_col", cb, 0);
    chk("rel_b_fs",  fsb, FS_ON);
    tick();
    chk("rel2_a_col", ca, 1);
    chk("rel2_a_fs",  fsa, 0);
    chk("rel2_b_col", cb, 1);
    chk("rel2_b_fs",  fsb, 0);
    bus_b.i_enable = 1'b0;

    // One full line on instance a, starting at (1,0)
    hs_low = 0; hs_first = -1; hs_last = -1; act_n = 0; bad = 0;
    for (int i = 0; i < 800; i++) begin
      if (hsa == 0) begin
        hs_low++;
        if (hs_first < 0) hs_first = ca;
        hs_last = ca;
      end
      if (aca == 1) act_n++;
      if (hsa != ((ca >= 656 && ca <= 751) ? 0 : 1)) bad++;
      if (aca != ((ca < 640 && ra < 480) ? 1 : 0)) bad++;
      tick();
    end
    chk("line_hs_low",   hs_low, 96);
    chk("line_hs_first", hs_first, 656);
    chk("line_hs_last",  hs_last, 751);
    chk("line_active",   act_n, 640);
    chk("line_decode",   bad, 0);
    chk("line_col_end",  ca, 1);
    chk("line_row_end",  ra, 1);

    // Freeze instance a at col 655 for 50 cycles
    found = (ca == 655) ? 1 : 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      tick();
      found = (ca == 655) ? 1 : 0;
    end
    chk("frz_reach", found, 1);
    chk("frz_hs_655", hsa, 1);
    bus_a.i_enable = 1'b0;
    s_c = ca; s_r = ra; s_hs = hsa; s_vs = vsa; s_ac = aca; s_fs = fsa;
    bad = 0;
    repeat (50) begin
      tick();
      if (ca != s_c || ra != s_r || hsa != s_hs || vsa != s_vs ||
          aca != s_ac || fsa != s_fs) bad++;
    end
    chk("frz_hold", bad, 0);
    bus_a.i_enable = 1'b1;
    tick();
    chk("frz_resume_col", ca, 656);
    chk("frz_resume_hs",  hsa, 0);

    // Two frames on instance b, starting at (1,0)
    bus_b.i_enable = 1'b1;
    org_n = 0; org_first = -1; org_last = -1; fs_n = 0; fs_bad = 0;
    vs_low = 0; vs_min = 999; vs_max = -1; act_n = 0; bad = 0;
    for (int i = 0; i < 1280; i++) begin
      tick();
      if (cb == 0 && rb == 0) begin
        org_n++;
        if (org_first < 0) org_first = i;
        org_last = i;
      end
      if (fsb == 1) begin
        fs_n++;
        if (!(cb == 0 && rb == 0)) fs_bad++;
      end
      if (vsb == 0) begin
        vs_low++;
        if (rb < vs_min) vs_min = rb;
        if (rb > vs_max) vs_max = rb;
      end
      if (acb == 1) act_n++;
      if (vsb != ((rb >= 12 && rb <= 13) ? 0 : 1)) bad++;
      if (hsb != ((cb >= 28 && cb <= 33) ? 0 : 1)) bad++;
    end
    chk("frm_origins", org_n, 2);
    chk("frm_period",  org_last - org_first, 640);
    chk("frm_fs_count", fs_n, 2 * FS_ON);
    chk("frm_fs_misplaced", fs_bad, 0);
    chk("frm_vs_low",  vs_low, 160);
    chk("frm_vs_min",  vs_min, 12);
    chk("frm_vs_max",  vs_max, 13);
    chk("frm_active",  act_n, 480);
    chk("frm_decode",  bad, 0);

    // Stall instance b at (0,0): frame pulse must not stretch
    found = 0;
    for (int i = 0; i < 700 && found == 0; i++) begin
      tick();
      found = (cb == 0 && rb == 0) ? 1 : 0;
    end
    chk("stall_reach", found, 1);
    chk("stall_fs_first", fsb, FS_ON);
    bus_b.i_enable = 1'b0;
    tick();
    chk("stall_fs_second", fsb, 0);
    chk("stall_col", cb, 0);
    chk("stall_row", rb, 0);
    tick();
    chk("stall_fs_third", fsb, 0);

    // Asynchronous reset with instance b inside both sync pulses
    bus_b.i_enable = 1'b1;
    found = 0;
    for (int i = 0; i < 700 && found == 0; i++) begin
      tick();
      found = (cb == 30 && rb == 13) ? 1 : 0;
    end
    chk("arst_reach", found, 1);
    chk("arst_pre_hs", hsb, 0);
    chk("arst_pre_vs", vsb, 0);
    #2;
    rst_n = 1'b0;
    #1;
    sample();
    check_rst("arst_now");
    tick();
    check_rst("arst_held");
    rst_n = 1'b1;
    tick();
    chk("arst_rel_a_col", ca, 0);
    chk("arst_rel_a_row", ra, 0);
    chk("arst_rel_a_fs",  fsa, FS_ON);
    chk("arst_rel_b_col", cb, 0);
    chk("arst_rel_b_row", rb, 0);
    chk("arst_rel_b_fs",  fsb, FS_ON);
    tick();
    chk("arst_rel2_a_col", ca, 1);
    chk("arst_rel2_a_fs",  fsa, 0);
    chk("arst_rel2_b_col", cb, 1);
    chk("arst_rel2_b_fs",  fsb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
